// File: rtl/bcd_calc_engine.sv
// Multi-digit BCD calculator core.
// Two N_DIG-digit BCD operands are stepped by per-digit increment pulses. An accepted request
// computes A+B, A-B, A*B (shift-add, W cycles) or A/B (restoring division, W cycles). The binary
// result is then converted to BCD by a sequential double-dabble (RW cycles).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   inc_i          digit increment pulses, {A digits, B digits}, MS digit at top
//   mode_toggle_i  flips entry_mode_o while idle
//   op_valid_i     request; op_code_i 00 add, 01 sub, 10 mul, 11 div
//   op_ready_o     high only while idle
//   entry_mode_o   1 = operand entry/display, 0 = result display
//   opnd_bcd_o     {A digits, B digits}
//   res_bcd_o      result magnitude (2*N_DIG BCD digits), res_neg_o sign (sub only)
//   err_o          divide-by-zero, done_o one-cycle result-update pulse
module bcd_calc_engine #(
  parameter int unsigned N_DIG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N_DIG-1:0]   inc_i,
  input  logic                 mode_toggle_i,
  input  logic                 op_valid_i,
  input  logic [1:0]           op_code_i,
  output logic                 op_ready_o,
  output logic                 entry_mode_o,
  output logic [8*N_DIG-1:0]   opnd_bcd_o,
  output logic [8*N_DIG-1:0]   res_bcd_o,
  output logic                 res_neg_o,
  output logic                 err_o,
  output logic                 done_o
);

  localparam int unsigned W  = $clog2(10**N_DIG);
  localparam int unsigned RW = $clog2(10**(2*N_DIG));
  localparam int unsigned ND = 2 * N_DIG;
  localparam int unsigned CW = $clog2(RW) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StConv, StDone} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic [RW-1:0]           acc_q, acc_d;
  logic [W:0]              rem_q, rem_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*ND-1:0]         bcd_q, bcd_d;
  logic [ND-1:0][3:0]      dig_q, dig_d;
  logic                    entry_q, entry_d;
  logic [4*ND-1:0]         res_bcd_q, res_bcd_d;
  logic                    res_neg_q, res_neg_d;
  logic                    neg_q, neg_d;
  logic                    err_q, err_d;

  logic [W-1:0]            a_bin, b_bin;
  logic [4*ND-1:0]         bcd_adj;
  logic [W:0]              rem_sh;

  // Binary values of the operand digits.
  always_comb begin
    a_bin = '0;
    b_bin = '0;
    for (int i = int'(ND) - 1; i >= int'(N_DIG); i--) a_bin = a_bin * W'(10) + W'(dig_q[i]);
    for (int i = int'(N_DIG) - 1; i >= 0; i--) b_bin = b_bin * W'(10) + W'(dig_q[i]);
  end

  // Double-dabble correction: add 3 to each nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(ND); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign rem_sh = {rem_q[W-1:0], a_q[W-1]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    dig_d     = dig_q;
    entry_d   = entry_q;
    res_bcd_d = res_bcd_q;
    res_neg_d = res_neg_q;
    neg_d     = neg_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (entry_q && !op_valid_i) begin
          for (int i = 0; i < int'(ND); i++) begin
            if (inc_i[i]) dig_d[i] = (dig_q[i] == 4'd9) ? 4'd0 : dig_q[i] + 4'd1;
          end
        end
        entry_d = entry_q ^ mode_toggle_i;
        if (op_valid_i) begin
          op_d  = op_code_i;
          a_d   = a_bin;
          b_d   = b_bin;
          acc_d = '0;
          rem_d = '0;
          cnt_d = '0;
          bcd_d = '0;
          neg_d = 1'b0;
          if (op_code_i == 2'b11 && b_bin == '0) begin
            // Divide by zero: report straight away, no calculation or conversion.
            state_d   = StDone;
            res_bcd_d = '0;
            res_neg_d = 1'b0;
            err_d     = 1'b1;
            entry_d   = 1'b0;
          end else begin
            state_d = StCalc;
          end
        end
      end

      StCalc: begin
        unique case (op_q)
          2'b00: begin
            acc_d   = RW'(a_q) + RW'(b_q);
            state_d = StConv;
          end
          2'b01: begin
            neg_d   = a_q < b_q;
            acc_d   = (a_q < b_q) ? RW'(b_q - a_q) : RW'(a_q - b_q);
            state_d = StConv;
          end
          2'b10: begin
            // MSB-first shift-add keeps the multiplicand at operand width.
            acc_d = (acc_q << 1) + (b_q[W-1] ? RW'(a_q) : RW'(0));
            b_d   = b_q << 1;
          end
          default: begin
            // Restoring division; quotient bits shift into a_q as the dividend shifts out.
            if (rem_sh >= {1'b0, b_q}) begin
              rem_d = rem_sh - {1'b0, b_q};
              a_d   = {a_q[W-2:0], 1'b1};
            end else begin
              rem_d = rem_sh;
              a_d   = {a_q[W-2:0], 1'b0};
            end
            acc_d = RW'(a_d);
          end
        endcase
        if (op_q[1]) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            cnt_d   = '0;
            state_d = StConv;
          end
        end
      end

      StConv: begin
        bcd_d = {bcd_adj[4*ND-2:0], acc_q[RW-1]};
        acc_d = acc_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RW - 1)) begin
          state_d   = StDone;
          res_bcd_d = {bcd_adj[4*ND-2:0], acc_q[RW-1]};
          res_neg_d = neg_q;
          err_d     = 1'b0;
          entry_d   = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      dig_q     <= '0;
      entry_q   <= 1'b1;
      res_bcd_q <= '0;
      res_neg_q <= 1'b0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      dig_q     <= dig_d;
      entry_q   <= entry_d;
      res_bcd_q <= res_bcd_d;
      res_neg_q <= res_neg_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
    end
  end

  assign op_ready_o   = state_q == StIdle;
  assign done_o       = state_q == StDone;
  assign entry_mode_o = entry_q;
  assign opnd_bcd_o   = dig_q;
  assign res_bcd_o    = res_bcd_q;
  assign res_neg_o    = res_neg_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_bcd_calc_engine.sv
module tb_bcd_calc_engine;

  localparam int N  = 2;
  localparam int ND = 2 * N;
  localparam int W  = $clog2(10**N);
  localparam int RW = $clog2(10**(2*N));

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ND-1:0]     inc = '0;
  logic              tog = 1'b0;
  logic              vld = 1'b0;
  logic [1:0]        code = 2'b00;
  logic              op_ready, entry_mode, res_neg, err, done;
  logic [8*N-1:0]    opnd, res;

  bcd_calc_engine #(.N_DIG(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .inc_i         (inc),
    .mode_toggle_i (tog),
    .op_valid_i    (vld),
    .op_code_i     (code),
    .op_ready_o    (op_ready),
    .entry_mode_o  (entry_mode),
    .opnd_bcd_o    (opnd),
    .res_bcd_o     (res),
    .res_neg_o     (res_neg),
    .err_o         (err),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: decimal digits, a countdown to the done cycle, integer results.
  int m_dig[ND];
  bit m_entry, m_busy, m_done, m_neg, m_err, p_neg;
  int m_left, m_res, p_res;

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 0;
    m_entry = 1; m_busy = 0; m_done = 0; m_neg = 0; m_err = 0; m_res = 0; m_left = 0;
  endtask

  task automatic model_step();
    int a, b, c;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_res = p_res; m_neg = p_neg; m_err = 0; m_entry = 0;
      end
    end else begin
      if (m_entry && !vld)
        for (int i = 0; i < ND; i++) if (inc[i]) m_dig[i] = (m_dig[i] + 1) % 10;
      if (tog) m_entry = !m_entry;
      if (vld) begin
        a = 0; b = 0;
        for (int i = ND - 1; i >= N; i--) a = a * 10 + m_dig[i];
        for (int i = N - 1; i >= 0; i--) b = b * 10 + m_dig[i];
        p_neg = 0;
        c = 1;
        case (code)
          2'b00: p_res = a + b;
          2'b01: begin p_neg = a < b; p_res = (a < b) ? b - a : a - b; end
          2'b10: begin p_res = a * b; c = W; end
          default: begin p_res = (b == 0) ? 0 : a / b; c = W; end
        endcase
        if (code == 2'b11 && b == 0) begin
          m_done = 1; m_res = 0; m_neg = 0; m_err = 1; m_entry = 0;
        end else begin
          m_busy = 1; m_left = c + RW;
        end
      end
    end
  endtask

  function automatic logic [8*N-1:0] to_bcd(int v);
    logic [8*N-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [8*N-1:0] opnd_exp();
    logic [8*N-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(m_dig[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("op_ready", 32'(op_ready), 32'(!(m_busy || m_done)));
      chk("entry_mode", 32'(entry_mode), 32'(m_entry));
      chk("opnd_bcd", 32'(opnd), 32'(opnd_exp()));
      chk("res_bcd", 32'(res), 32'(to_bcd(m_res)));
      chk("res_neg", 32'(res_neg), 32'(m_neg));
      chk("err", 32'(err), 32'(m_err));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  task automatic cycle(input logic [ND-1:0] i_inc, input logic i_tog, input logic i_vld,
                       input logic [1:0] i_code, input logic i_rst);
    inc = i_inc; tog = i_tog; vld = i_vld; code = i_code; rst = i_rst;
    @(posedge clk);
    model_step();
    #1;
    inc = '0; tog = 1'b0; vld = 1'b0; rst = 1'b0;
  endtask

  task automatic set_digits(input int a, input int b);
    int td[ND];
    logic [ND-1:0] mask;
    for (int j = 0; j < N; j++) begin
      td[N + j] = (a / (10**j)) % 10;
      td[j]     = (b / (10**j)) % 10;
    end
    if (!m_entry) cycle('0, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      mask = '0;
      for (int i = 0; i < ND; i++) if (m_dig[i] != td[i]) mask[i] = 1'b1;
      if (mask == '0) break;
      cycle(mask, 1'b0, 1'b0, 2'b00, 1'b0);
    end
  endtask

  // Issue one op, then measure latency to done (bounded) and check the literal result.
  task automatic run_op(input logic [1:0] op, input int exp_lat, input logic [15:0] exp_res,
                        input logic exp_neg, input logic exp_err, input bit noisy);
    int n;
    cycle('0, 1'b0, 1'b1, op, 1'b0);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (done) break;
      if (noisy && n == 1) chk("busy_ready", 32'(op_ready), 32'd0);
      if (noisy) cycle(ND'($urandom), 1'($urandom), 1'b1, 2'($urandom), 1'b0);
      else cycle('0, 1'b0, 1'b0, 2'b00, 1'b0);
      n++;
    end
    chk("latency", 32'(n + 1), 32'(exp_lat));
    chk("lit_res", 32'(res), 32'(exp_res));
    chk("lit_neg", 32'(res_neg), 32'(exp_neg));
    chk("lit_err", 32'(err), 32'(exp_err));
    cycle('0, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("lit_entry", 32'(entry_mode), 32'd0);
  endtask

  initial begin
    int r;
    model_reset();
    cycle('0, 1'b0, 1'b0, 2'b00, 1'b1);
    cycle('0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk_en = 1'b1;
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_entry", 32'(entry_mode), 32'd1);
    chk("rst_opnd", 32'(opnd), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Directed cases with hand-computed expectations.
    set_digits(47, 25);
    chk("opnd_4725", 32'(opnd), 32'h4725);
    run_op(2'b00, 16, 16'h0072, 1'b0, 1'b0, 1'b0);
    set_digits(25, 47);
    run_op(2'b01, 16, 16'h0022, 1'b1, 1'b0, 1'b0);
    set_digits(47, 25);
    run_op(2'b01, 16, 16'h0022, 1'b0, 1'b0, 1'b0);
    set_digits(99, 99);
    run_op(2'b10, 22, 16'h9801, 1'b0, 1'b0, 1'b1);
    set_digits(85, 0);
    run_op(2'b11, 1, 16'h0000, 1'b0, 1'b1, 1'b0);
    set_digits(85, 4);
    run_op(2'b11, 22, 16'h0021, 1'b0, 1'b0, 1'b0);

    // Digit wrap, simultaneous steps, and inc ignored in result mode.
    set_digits(91, 9);
    cycle(4'b1001, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("wrap_opnd", 32'(opnd), 32'h0100);
    cycle('0, 1'b1, 1'b0, 2'b00, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("noentry_opnd", 32'(opnd), 32'h0100);
    cycle('0, 1'b1, 1'b0, 2'b00, 1'b0);

    // Reset in the middle of a multiply's conversion.
    set_digits(12, 34);
    cycle('0, 1'b0, 1'b1, 2'b10, 1'b0);
    repeat (W + 3) cycle('0, 1'b0, 1'b0, 2'b00, 1'b0);
    cycle('0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("abort_ready", 32'(op_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_opnd", 32'(opnd), 32'd0);
    chk("abort_entry", 32'(entry_mode), 32'd1);
    repeat (30) cycle('0, 1'b0, 1'b0, 2'b00, 1'b0);

    // Randomized traffic against the model.
    repeat (3000) begin
      r = $urandom_range(0, 199);
      cycle(($urandom_range(0, 2) == 0) ? ND'($urandom) : '0, r < 8,
            (r >= 8 && r < 30), 2'($urandom), r == 199);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
